// File: rtl/interleaver_ctrl.sv
// Sequencer around the combinational turbo interleaver: gathers a byte block,
// holds it for a settle window, captures the permutation and streams both copies.
module interleaver_ctrl #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_first,
  input  logic              s_size,
  input  logic [DATA_W-1:0] s_data,
  output logic [6143:0]     il_cin,
  output logic              il_k_eq_6144,
  input  logic [6143:0]     il_cout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_sys,
  output logic [DATA_W-1:0] m_int,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, UNLOAD} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t        state, state_nx;
  logic [9:0]    cnt;
  logic [3:0]    settle_cnt;
  logic [6143:0] cap;
  logic          s_fire, m_fire;
  logic [9:0]    last_idx, out_idx;

  // Byte n of a K-bit block sits at [K-1-8n -: 8]; returns that MSB position.
  function automatic logic [12:0] byte_msb(input logic big, input logic [9:0] n);
    logic [12:0] top;
    top = big ? 13'd6143 : 13'd1055;
    return top - {n, 3'b000};
  endfunction

  assign s_fire   = s_valid && s_ready;
  assign m_fire   = m_valid && m_ready;
  assign last_idx = il_k_eq_6144 ? 10'd767 : 10'd131;
  assign out_idx  = m_valid ? cnt + 10'd1 : cnt;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s_fire && s_first) state_nx = LOAD;
      LOAD:    if (s_fire && !s_first && cnt == last_idx) state_nx = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nx = UNLOAD;
      UNLOAD:  if (m_fire && m_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // In UNLOAD the first cycle primes the output registers; afterwards each
  // accepted beat loads the next byte so the stream runs at full rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready      <= 1'b0;
      il_cin       <= '0;
      il_k_eq_6144 <= 1'b0;
      cap          <= '0;
      cnt          <= '0;
      settle_cnt   <= '0;
      m_valid      <= 1'b0;
      m_sys        <= '0;
      m_int        <= '0;
      m_last       <= 1'b0;
      err          <= 1'b0;
    end else begin
      s_ready <= (state_nx == IDLE) || (state_nx == LOAD);
      err     <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (s_fire) begin
            if (s_first) begin
              il_cin <= '0;
              il_cin[byte_msb(s_size, 10'd0) -: DATA_W] <= s_data;
              il_k_eq_6144 <= s_size;
              cnt <= 10'd1;
              err <= (state == LOAD);
            end else if (state == IDLE) begin
              err <= 1'b1;
            end else begin
              il_cin[byte_msb(il_k_eq_6144, cnt) -: DATA_W] <= s_data;
              if (cnt == last_idx) begin
                cnt        <= '0;
                settle_cnt <= '0;
              end else begin
                cnt <= cnt + 10'd1;
              end
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            cap <= il_cout;
            cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        UNLOAD: begin
          if (!m_valid || m_ready) begin
            if (m_valid && m_last) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end else begin
              if (m_valid) cnt <= cnt + 10'd1;
              m_valid <= 1'b1;
              m_sys   <= il_cin[byte_msb(il_k_eq_6144, out_idx) -: DATA_W];
              m_int   <= cap[byte_msb(il_k_eq_6144, out_idx) -: DATA_W];
              m_last  <= (out_idx == last_idx);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Scoreboard bench for interleaver_ctrl with an inverting or QPP interleaver model.
module tb_interleaver_ctrl;
  localparam int S = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          s_valid = 1'b0, s_first = 1'b0, s_size = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready, il_k_eq_6144, m_valid, m_ready, m_last, busy, err;
  logic [6143:0] il_cin, il_cout;
  logic [7:0]    m_sys, m_int;

  typedef struct {
    logic [7:0] sys;
    logic [7:0] intl;
    logic       last;
  } beat_t;

  beat_t      sb[$];
  logic [7:0] blk[768];
  int         vectors = 0, miscompares = 0, cyc = 0, beats_seen = 0;
  bit         il_mode = 0, ready_toggle = 0;

  interleaver_ctrl #(.DATA_W(8), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_first(s_first),
    .s_size(s_size), .s_data(s_data), .il_cin(il_cin), .il_k_eq_6144(il_k_eq_6144),
    .il_cout(il_cout), .m_valid(m_valid), .m_ready(m_ready), .m_sys(m_sys), .m_int(m_int),
    .m_last(m_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference QPP interleaver: output bit j of the sequence is input bit pi(j).
  function automatic logic [6143:0] qpp(input logic [6143:0] c, input logic big);
    logic [6143:0] o;
    longint k, f1, f2, p;
    o  = '0;
    k  = big ? 6144 : 1056;
    f1 = big ? 263 : 17;
    f2 = big ? 480 : 66;
    for (longint j = 0; j < k; j++) begin
      p = (f1 * j + f2 * j * j) % k;
      o[int'(k - 1 - j)] = c[int'(k - 1 - p)];
    end
    return o;
  endfunction

  assign il_cout = il_mode ? qpp(il_cin, il_k_eq_6144) : ~il_cin;

  function automatic logic [6143:0] build_vec(input bit big);
    logic [6143:0] v;
    int top, n;
    v   = '0;
    top = big ? 6143 : 1055;
    n   = big ? 768 : 132;
    for (int i = 0; i < n; i++) v[top - 8 * i -: 8] = blk[i];
    return v;
  endfunction

  task automatic push_expected(input bit big);
    logic [6143:0] v, c;
    beat_t e;
    int top, n;
    v   = build_vec(big);
    c   = il_mode ? qpp(v, big) : ~v;
    top = big ? 6143 : 1055;
    n   = big ? 768 : 132;
    for (int i = 0; i < n; i++) begin
      e.sys  = v[top - 8 * i -: 8];
      e.intl = c[top - 8 * i -: 8];
      e.last = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_byte(input bit first, input bit size, input logic [7:0] d);
    bit done = 0;
    s_valid = 1'b1; s_first = first; s_size = size; s_data = d;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("[TB] FAIL send_timeout accepted=0 required=1");
    end
    s_valid = 1'b0; s_first = 1'b0;
  endtask

  task automatic send_block(input bit big);
    int n = big ? 768 : 132;
    for (int i = 0; i < n; i++) send_byte(i == 0, big, blk[i]);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int t = 0; t < 5000 && !ok; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !m_valid) ok = 1;
    end
  endtask

  // Scoreboard: every accepted output beat pops one expected beat.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst_n && m_valid && m_ready) begin
      beats_seen++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_beat sys=%h int=%h last=%b required=none", m_sys, m_int, m_last);
      end else begin
        e = sb.pop_front();
        if ({m_sys, m_int, m_last} !== {e.sys, e.intl, e.last}) begin
          miscompares++;
          $display("[TB] FAIL beat got sys=%h int=%h last=%b required sys=%h int=%h last=%b",
                   m_sys, m_int, m_last, e.sys, e.intl, e.last);
        end
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = ready_toggle ? ~m_ready : 1'b1;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_s_ready got=%b required=0", s_ready); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_m_valid got=%b required=0", m_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy got=%b required=0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_err got=%b required=0", err); end
    vectors++; if (il_cin !== '0) begin miscompares++; $display("[TB] FAIL rst_il_cin got=nonzero required=0"); end
    vectors++; if (il_k_eq_6144 !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_k got=%b required=0", il_k_eq_6144); end
    vectors++;
    if ({m_sys, m_int, m_last} !== 17'd0) begin
      miscompares++; $display("[TB] FAIL rst_m_data got=%h/%h/%b required=0", m_sys, m_int, m_last);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL post_rst_s_ready got=%b required=1", s_ready); end
  endtask

  task automatic test_small_block;
    int t0, lat;
    bit ok;
    il_mode = 0; ready_toggle = 0;
    for (int i = 0; i < 132; i++) blk[i] = 8'(i);
    push_expected(0);
    send_block(0);
    t0 = cyc;
    vectors++;
    if (il_cin !== build_vec(0)) begin
      miscompares++; $display("[TB] FAIL small_il_cin got_hi=%h required_hi=0", il_cin[6143:6112]);
    end
    vectors++; if (il_k_eq_6144 !== 1'b0) begin miscompares++; $display("[TB] FAIL small_k got=%b required=0", il_k_eq_6144); end
    lat = -1;
    for (int t = 0; t < 50 && lat < 0; t++) begin
      @(negedge clk);
      if (m_valid) lat = cyc - t0;
    end
    vectors++; if (lat != S + 1) begin miscompares++; $display("[TB] FAIL latency got=%0d required=%0d", lat, S + 1); end
    wait_done(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL small_drain left=%0d required=0", sb.size()); end
  endtask

  task automatic test_big_block;
    int b0;
    bit ok;
    il_mode = 1; ready_toggle = 1;
    for (int i = 0; i < 768; i++) blk[i] = 8'hA5;
    push_expected(1);
    b0 = beats_seen;
    send_block(1);
    vectors++; if (il_k_eq_6144 !== 1'b1) begin miscompares++; $display("[TB] FAIL big_k got=%b required=1", il_k_eq_6144); end
    wait_done(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL big_drain left=%0d required=0", sb.size()); end
    vectors++;
    if (beats_seen - b0 != 768) begin
      miscompares++; $display("[TB] FAIL big_beats got=%0d required=768", beats_seen - b0);
    end
    il_mode = 0; ready_toggle = 0;
  endtask

  task automatic test_stray_byte;
    bit ok;
    send_byte(0, 0, 8'h77);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL stray_err got=%b required=1", err); end
    @(posedge clk); #1;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL stray_err_clear got=%b required=0", err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL stray_busy got=%b required=0", busy); end
    for (int i = 0; i < 132; i++) blk[i] = 8'(i) ^ 8'h3C;
    push_expected(0);
    send_block(0);
    wait_done(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL stray_drain left=%0d required=0", sb.size()); end
  endtask

  task automatic test_restart;
    bit ok;
    send_byte(1, 0, 8'hEE);
    for (int i = 1; i < 50; i++) send_byte(0, 0, 8'hEE);
    for (int i = 0; i < 132; i++) blk[i] = 8'hC0 + 8'(i);
    push_expected(0);
    send_byte(1, 0, blk[0]);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("[TB] FAIL restart_err got=%b required=1", err); end
    for (int i = 1; i < 132; i++) send_byte(0, 0, blk[i]);
    wait_done(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL restart_drain left=%0d required=0", sb.size()); end
  endtask

  task automatic test_reset_unload;
    int b0;
    bit ok, hit;
    for (int i = 0; i < 132; i++) blk[i] = 8'h55 ^ 8'(i);
    push_expected(0);
    b0 = beats_seen;
    send_block(0);
    hit = 0;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (beats_seen - b0 >= 10) hit = 1;
    end
    vectors++; if (!hit) begin miscompares++; $display("[TB] FAIL unload_reach got=%0d required=10", beats_seen - b0); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_m_valid got=%b required=0", m_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL async_busy got=%b required=0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("[TB] FAIL async_err got=%b required=0", err); end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 132; i++) blk[i] = 8'hFF - 8'(i);
    push_expected(0);
    send_block(0);
    wait_done(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL post_reset_drain left=%0d required=0", sb.size()); end
  endtask

  task automatic test_back_to_back;
    bit ok, done, bad;
    ready_toggle = 0;
    for (int i = 0; i < 132; i++) blk[i] = 8'(i * 3);
    push_expected(0);
    send_block(0);
    done = 0; bad = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (s_ready !== 1'b0 && !bad) begin
        bad = 1; vectors++; miscompares++;
        $display("[TB] FAIL b2b_s_ready_low got=%b required=0 cycle=%0d", s_ready, t);
      end
      if (m_valid && m_ready && m_last) done = 1;
    end
    vectors++; if (!done) begin miscompares++; $display("[TB] FAIL b2b_last got=0 required=1"); end
    @(posedge clk); #1;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_s_ready_high got=%b required=1", s_ready); end
    for (int i = 0; i < 132; i++) blk[i] = 8'(i * 7);
    push_expected(0);
    send_block(0);
    wait_done(ok);
    vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL b2b_drain left=%0d required=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_small_block();
    test_big_block();
    test_stray_byte();
    test_restart();
    test_reset_unload();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog elapsed=1 required=0");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
